// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: standard VGA timing constants and a counter-width helper.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
  localparam int   VGA640_H_ACTIVE = 640;
  localparam int   VGA640_H_FP     = 16;
  localparam int   VGA640_H_SYNC   = 96;
  localparam int   VGA640_H_BP     = 48;
  localparam int   VGA640_V_ACTIVE = 480;
  localparam int   VGA640_V_FP     = 10;
  localparam int   VGA640_V_SYNC   = 2;
  localparam int   VGA640_V_BP     = 33;
  localparam logic VGA640_HS_POL   = 1'b0;
  localparam logic VGA640_VS_POL   = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
  localparam int   VGA800_H_ACTIVE = 800;
  localparam int   VGA800_H_FP     = 40;
  localparam int   VGA800_H_SYNC   = 128;
  localparam int   VGA800_H_BP     = 88;
  localparam int   VGA800_V_ACTIVE = 600;
  localparam int   VGA800_V_FP     = 1;
  localparam int   VGA800_V_SYNC   = 4;
  localparam int   VGA800_V_BP     = 23;
  localparam logic VGA800_HS_POL   = 1'b1;
  localparam logic VGA800_VS_POL   = 1'b1;

  // A total fits when every count 0..total-1 and the total itself are representable.
  function automatic bit fits_cw(input int total, input int cw);
    return total < (1 << cw);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis -- position counter with wrap, plus active/sync/zero decode.
// Latency: decode outputs are combinational on the current count; count moves 1 clk after adv.
// Backpressure: none; the counter only moves on clocks with adv=1.
// Ports: clk, clr (sync, active-high) | adv: advance one step | cnt: current position |
//        carry: adv on the last position (wrap this clk) | at_zero, in_active, in_sync: decode of cnt.
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic          carry,
  output logic          at_zero,
  output logic          in_active,
  output logic          in_sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  // Feeds the next axis so it steps on the same clk this one wraps.
  assign carry     = adv & (cnt_q == LAST);
  assign at_zero   = (cnt_q == '0);
  assign in_active = (cnt_q < ACT_END);
  assign in_sync   = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing -- syncs, data enable, active coordinates, line/frame strobes.
// Latency: 1 clk; outputs describe the counter position sampled on the previous pix_en clk.
// Backpressure: none; pix_en paces the raster, outputs hold and strobes drop while it is low.
// Ports: clk, clr (sync, active-high), pix_en | hsync, vsync, de, x, y, hc, vc, line_start, frame_start.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic HS_POL   = VGA640_HS_POL,
  parameter logic VS_POL   = VGA640_VS_POL,
  parameter int   CW       = 11
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (!fits_cw(H_TOTAL, CW)) begin : g_h_total_too_wide
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (!fits_cw(V_TOTAL, CW)) begin : g_v_total_too_wide
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_carry, v_carry_unused;
  logic          h_zero, v_zero, h_act, v_act, h_sync, v_sync;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .clk       (clk),
    .clr       (clr),
    .adv       (pix_en),
    .cnt       (h_cnt),
    .carry     (h_carry),
    .at_zero   (h_zero),
    .in_active (h_act),
    .in_sync   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .clk       (clk),
    .clr       (clr),
    .adv       (h_carry),
    .cnt       (v_cnt),
    .carry     (v_carry_unused),
    .at_zero   (v_zero),
    .in_active (v_act),
    .in_sync   (v_sync)
  );

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, hc_q, hc_d, vc_q, vc_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Level outputs hold between enables; strobes are single-clk and drop when pix_en is low.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    hc_d          = hc_q;
    vc_d          = vc_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      hsync_d       = h_sync ? HS_POL : ~HS_POL;
      vsync_d       = v_sync ? VS_POL : ~VS_POL;
      de_d          = h_act & v_act;
      x_d           = (h_act & v_act) ? h_cnt : '0;
      y_d           = (h_act & v_act) ? v_cnt : '0;
      hc_d          = h_cnt;
      vc_d          = v_cnt;
      line_start_d  = h_zero;
      frame_start_d = h_zero & v_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
    logic hp, vp;
  } cfg_t;

  typedef struct {
    logic hs, vs, de, ls, fs;
    int   x, y, hc, vc;
  } px_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  // instance 0: default 640x480 timing
  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic [10:0] d_x, d_y, d_hc, d_vc;
  // instance 1: tiny 8x6 raster with positive syncs
  logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic [10:0] s_x, s_y, s_hc, s_vc;
  // instance 2: mid-size 32x17 raster, negative syncs
  logic m_hs, m_vs, m_de, m_ls, m_fs;
  logic [10:0] m_x, m_y, m_hc, m_vc;

  vga_timing_gen u_def (
    .clk(clk), .clr(clr), .pix_en(pix_en),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y), .hc(d_hc), .vc(d_vc),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) u_sml (
    .clk(clk), .clr(clr), .pix_en(pix_en),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y), .hc(s_hc), .vc(s_vc),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(11)
  ) u_med (
    .clk(clk), .clr(clr), .pix_en(pix_en),
    .hsync(m_hs), .vsync(m_vs), .de(m_de), .x(m_x), .y(m_y), .hc(m_hc), .vc(m_vc),
    .line_start(m_ls), .frame_start(m_fs)
  );

  cfg_t  cfg[3];
  string nm[3];
  px_t   exp_px[3];
  int    pos[3];
  int    n_checks = 0;
  int    n_fail = 0;
  int    ph = 0;
  bit    upd = 1'b0;
  bit    armed = 1'b0;

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic px_t get_obs(input int i);
    px_t o;
    case (i)
      0: begin
        o.hs = d_hs; o.vs = d_vs; o.de = d_de; o.ls = d_ls; o.fs = d_fs;
        o.x = int'(d_x); o.y = int'(d_y); o.hc = int'(d_hc); o.vc = int'(d_vc);
      end
      1: begin
        o.hs = s_hs; o.vs = s_vs; o.de = s_de; o.ls = s_ls; o.fs = s_fs;
        o.x = int'(s_x); o.y = int'(s_y); o.hc = int'(s_hc); o.vc = int'(s_vc);
      end
      default: begin
        o.hs = m_hs; o.vs = m_vs; o.de = m_de; o.ls = m_ls; o.fs = m_fs;
        o.x = int'(m_x); o.y = int'(m_y); o.hc = int'(m_hc); o.vc = int'(m_vc);
      end
    endcase
    return o;
  endfunction

  function automatic int h_tot(input cfg_t c);
    return c.ha + c.hf + c.hsw + c.hb;
  endfunction

  function automatic int f_tot(input cfg_t c);
    return h_tot(c) * (c.va + c.vf + c.vsw + c.vb);
  endfunction

  // Pixel n of the frame (raster order) mapped to what the outputs must show for it.
  function automatic px_t decode(input cfg_t c, input int n);
    px_t e;
    int h, v;
    h = n % h_tot(c);
    v = n / h_tot(c);
    e.de = (h < c.ha) && (v < c.va);
    e.x  = e.de ? h : 0;
    e.y  = e.de ? v : 0;
    e.hc = h;
    e.vc = v;
    e.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hp : ~c.hp;
    e.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vp : ~c.vp;
    e.ls = (h == 0);
    e.fs = (n == 0);
    return e;
  endfunction

  task automatic model_step(input logic c, input logic e);
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        pos[i] = 0;
        exp_px[i].hs = ~cfg[i].hp;
        exp_px[i].vs = ~cfg[i].vp;
        exp_px[i].de = 1'b0;
        exp_px[i].ls = 1'b0;
        exp_px[i].fs = 1'b0;
        exp_px[i].x = 0; exp_px[i].y = 0; exp_px[i].hc = 0; exp_px[i].vc = 0;
      end else if (e) begin
        exp_px[i] = decode(cfg[i], pos[i]);
        pos[i] = (pos[i] + 1) % f_tot(cfg[i]);
      end else begin
        exp_px[i].ls = 1'b0;
        exp_px[i].fs = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    px_t o, p;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      p = exp_px[i];
      chk($sformatf("%s.hsync", nm[i]), int'(o.hs), int'(p.hs));
      chk($sformatf("%s.vsync", nm[i]), int'(o.vs), int'(p.vs));
      chk($sformatf("%s.de", nm[i]), int'(o.de), int'(p.de));
      chk($sformatf("%s.line_start", nm[i]), int'(o.ls), int'(p.ls));
      chk($sformatf("%s.frame_start", nm[i]), int'(o.fs), int'(p.fs));
      chk($sformatf("%s.x", nm[i]), o.x, p.x);
      chk($sformatf("%s.y", nm[i]), o.y, p.y);
      chk($sformatf("%s.hc", nm[i]), o.hc, p.hc);
      chk($sformatf("%s.vc", nm[i]), o.vc, p.vc);
    end
  endtask

  // Drive one clk of inputs, then check every instance against the model after the edge.
  task automatic step(input logic c, input logic e);
    clr = c;
    pix_en = e;
    @(posedge clk);
    #1;
    model_step(c, e);
    if (c) armed = 1'b1;
    if (armed) compare_all();
    upd = e;
  endtask

  // Count clks between consecutive line or frame strobes of instance i, and tally
  // de / hsync-active / vsync-active / line_start over the updated pixels in that window.
  task automatic measure(input int i, input bit use_line, input int div, input int e_per,
                         input int e_de, input int e_hs, input int e_vs, input int e_ls);
    px_t o;
    bit  got;
    int  k, per, n_de, n_hs, n_vs, n_ls;
    got = 1'b0;
    k = 0;
    while (!got && k < 2 * e_per + 8) begin
      step(1'b0, (ph % div) == 0);
      ph++;
      k++;
      o = get_obs(i);
      got = use_line ? o.ls : o.fs;
    end
    if (!got) begin
      chk($sformatf("%s.strobe_timeout", nm[i]), 0, 1);
      return;
    end
    n_de = int'(o.de);
    n_hs = int'(o.hs == cfg[i].hp);
    n_vs = int'(o.vs == cfg[i].vp);
    n_ls = 1;
    per  = 0;
    got  = 1'b0;
    while (!got && per < 2 * e_per + 8) begin
      step(1'b0, (ph % div) == 0);
      ph++;
      per++;
      o = get_obs(i);
      got = use_line ? o.ls : o.fs;
      if (!got && upd) begin
        n_de += int'(o.de);
        n_hs += int'(o.hs == cfg[i].hp);
        n_vs += int'(o.vs == cfg[i].vp);
        n_ls += int'(o.ls);
      end
    end
    chk($sformatf("%s.period_div%0d", nm[i], div), per, e_per);
    chk($sformatf("%s.de_count", nm[i]), n_de, e_de);
    chk($sformatf("%s.hsync_count", nm[i]), n_hs, e_hs);
    chk($sformatf("%s.vsync_count", nm[i]), n_vs, e_vs);
    chk($sformatf("%s.line_starts", nm[i]), n_ls, e_ls);
  endtask

  initial begin
    px_t o;
    int  k;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    cfg[2] = '{20, 3, 5, 4, 10, 2, 3, 2, 1'b0, 1'b0};
    nm[0] = "def";
    nm[1] = "sml";
    nm[2] = "med";
    for (int i = 0; i < 3; i++) pos[i] = 0;

    // reset, then idle: outputs sit at reset values
    repeat (3) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      chk($sformatf("%s.first_fs", nm[i]), int'(o.fs), 1);
      chk($sformatf("%s.first_hc", nm[i]), o.hc, 0);
    end

    // frame / line statistics, continuous and divided pixel enables
    measure(1, 1'b0, 1, 48, 12, 12, 8, 6);
    measure(1, 1'b0, 2, 96, 12, 12, 8, 6);
    measure(2, 1'b0, 1, 544, 200, 85, 96, 17);
    measure(2, 1'b0, 4, 2176, 200, 85, 96, 17);
    measure(0, 1'b1, 1, 800, 640, 96, 0, 1);
    measure(0, 1'b1, 3, 2400, 640, 96, 0, 1);

    // clear in mid-frame of the medium raster
    k = 0;
    do begin
      step(1'b0, 1'b1);
      k++;
      o = get_obs(2);
    end while (!(o.hc == 10 && o.vc == 5) && k < 2000);
    chk("med.seek_mid", int'(o.hc == 10 && o.vc == 5), 1);
    step(1'b1, 1'($urandom_range(0, 1)));
    o = get_obs(2);
    chk("med.clr_hc", o.hc, 0);
    chk("med.clr_vc", o.vc, 0);
    chk("med.clr_hsync", int'(o.hs), 1);
    step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      chk($sformatf("%s.post_clr_fs", nm[i]), int'(o.fs), 1);
      chk($sformatf("%s.post_clr_vc", nm[i]), o.vc, 0);
    end

    // last pixel of the tiny raster wraps straight to (0,0)
    k = 0;
    do begin
      step(1'b0, 1'b1);
      k++;
      o = get_obs(1);
    end while (!(o.hc == 7 && o.vc == 5) && k < 200);
    chk("sml.seek_last", int'(o.hc == 7 && o.vc == 5), 1);
    step(1'b0, 1'b1);
    o = get_obs(1);
    chk("sml.wrap_hc", o.hc, 0);
    chk("sml.wrap_vc", o.vc, 0);
    chk("sml.wrap_fs", int'(o.fs), 1);

    // random enables with occasional clears
    for (int n = 0; n < 20000; n++) begin
      step(1'($urandom_range(0, 2999) == 0), 1'($urandom_range(0, 99) < 60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, default 96, horizontal sync width (pixels).
REQ-004 Parameter H_BP, default 48, horizontal back porch (pixels).
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, default 2, vertical sync width (lines).
REQ-008 Parameter V_BP, default 33, vertical back porch (lines).
REQ-009 Parameter HS_POL, default 0, hsync active level; VS_POL, default 0, vsync active level.
REQ-010 Parameter CW, default 11, width of counters and coordinates.
REQ-011 clk  in  1  system clock; single clock domain.
REQ-012 clr  in  1  reset, synchronous, active-high.
REQ-013 pix_en  in  1  pixel-rate enable; one pixel advanced per clk with pix_en=1.
REQ-014 hsync, vsync  out  1 each  sync outputs at HS_POL/VS_POL when active.
REQ-015 de  out  1  data enable, high inside the active area.
REQ-016 x, y  out  CW each  active-area coordinates; 0 when de=0.
REQ-017 hc, vc  out  CW each  raw position counters of the pixel currently presented.
REQ-018 line_start, frame_start  out  1 each  one-clk strobes.

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; both SHALL fit in CW bits (elaboration error otherwise).
REQ-020 Line order SHALL be: active [0, H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], back porch; vertical identical with V_* values.
REQ-021 Internal h counter SHALL advance only on clk with pix_en=1, wrapping H_TOTAL-1 -> 0.
REQ-022 Internal v counter SHALL advance on the same pix_en clk on which h wraps (no one-pixel lag), wrapping V_TOTAL-1 -> 0.
REQ-023 All outputs SHALL be registered, updated only on pix_en clks, describing the counter position sampled on that clk (latency 1 clk).
REQ-024 de SHALL be 1 iff hc<H_ACTIVE and vc<V_ACTIVE; x=hc, y=vc when de=1, else both 0.
REQ-025 hsync SHALL be HS_POL for hc in the horizontal sync window, ~HS_POL elsewhere; vsync likewise on vc, independent of hc.
REQ-026 line_start SHALL pulse for the presented pixel hc=0; frame_start for hc=0,vc=0 (line_start also high then).
REQ-027 Strobes SHALL be 0 on any clk with pix_en=0; all other outputs hold.
REQ-028 pix_en held 1 continuously SHALL give exactly H_TOTAL*V_TOTAL pixels per frame and H_ACTIVE*V_ACTIVE de-high cycles.

Reset
REQ-029 clr=1 SHALL clear counters to 0 on the next clk edge regardless of pix_en, including mid-frame.
REQ-030 During reset outputs SHALL be: hsync=~HS_POL, vsync=~VS_POL, de=0, x=y=hc=vc=0, strobes 0.
REQ-031 First pix_en clk after clr falls SHALL present (0,0) with frame_start=1.

Structure
REQ-032 Package vga_timing_pkg SHALL hold default 640x480@60 timing constants and an 800x600@60 set (40/88/128/23/1/4/...); no typedefs needed.
REQ-033 One sub-module vga_axis_counter (count, wrap, sync and active decode for one axis), instantiated once per axis.

Verification
REQ-034 Defaults, pix_en=1 always: 420000 clks per frame_start; 307200 de-high; hsync low for hc 656..751; vsync low for vc 490..491.
REQ-035 pix_en 1-in-4: frame period 1680000 clks; strobes one clk wide; outputs stable between enables.
REQ-036 clr at hc=300,vc=200: next clk all outputs at reset values; first enable after release gives frame_start=1, hc=vc=0.
REQ-037 Params H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1: 8x6 frame, hsync high at hc 5..6, vsync high at vc 4, de 12 per frame.
REQ-038 Last pixel hc=799,vc=524 followed by hc=0,vc=0 on the next enable; line_start exactly once per line.
